// File: rtl/piezo_tone_decoder.sv
// -----------------------------------------------------------------------------
// piezo_tone_decoder
//
// Decodes the alarm tone being played on a piezo buzzer by measuring the
// period and high time of its drive waveform. Each interval between two rising
// edges is classified as NORM, BATT, OVR or BOTH, or as invalid when it matches
// none of them. LOCK_CNT consecutive intervals of the same class lock that tone
// onto the output.
//
// Ports
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   piezo     in   asynchronous buzzer drive waveform
//   piezo_n   in   asynchronous complementary buzzer drive
//   tone      out  [2:0] decoded tone: 0 none, 1 NORM, 2 BATT, 3 OVR, 4 BOTH
//   tone_vld  out  one-cycle pulse whenever tone changes
//   diff_err  out  sticky flag: piezo and piezo_n were not complementary
//
// Parameters
//   LOCK_CNT   consecutive matching periods needed to report a tone
//   TOL_SHIFT  match tolerance is nominal >> TOL_SHIFT
//   CNT_W      counter width; 17 gives the nominal buzzer timings. Every
//              nominal period/high value and the timeout scale with 2^CNT_W.
//
// Build option
//   PIEZO_DIFF_CHK_EN  when defined, synchronizes piezo_n and raises diff_err
//                      after 4 consecutive cycles with piezo == piezo_n.
//                      When undefined, diff_err is tied low and piezo_n is
//                      ignored.
// -----------------------------------------------------------------------------
module piezo_tone_decoder #(
    parameter int LOCK_CNT  = 4,
    parameter int TOL_SHIFT = 3,
    parameter int CNT_W     = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       piezo,
    input  logic       piezo_n,
    output logic [2:0] tone,
    output logic       tone_vld,
    output logic       diff_err
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   M_ONE   = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [MC_W-1:0]  MC_ONE  = {{(MC_W-1){1'b0}}, 1'b1};
    localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_CNT);

    // Nominal (period, high) per tone, expressed relative to 2^CNT_W.
    localparam logic [CNT_W:0] NORM_P = M_ONE << (CNT_W - 1);
    localparam logic [CNT_W:0] NORM_H = M_ONE << (CNT_W - 2);
    localparam logic [CNT_W:0] BATT_P = M_ONE << (CNT_W - 2);
    localparam logic [CNT_W:0] BATT_H = M_ONE << (CNT_W - 3);
    localparam logic [CNT_W:0] BOTH_H = (M_ONE << (CNT_W - 3)) + (M_ONE << (CNT_W - 4));
    localparam logic [CNT_W:0] OVR_P  = M_ONE << (CNT_W - 3);
    localparam logic [CNT_W:0] OVR_H  = M_ONE << (CNT_W - 4);

    localparam logic [2:0] TONE_NONE = 3'd0;
    localparam logic [2:0] TONE_NORM = 3'd1;
    localparam logic [2:0] TONE_BATT = 3'd2;
    localparam logic [2:0] TONE_OVR  = 3'd3;
    localparam logic [2:0] TONE_BOTH = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    function automatic logic in_tol(input logic [CNT_W:0] val, input logic [CNT_W:0] nom);
        logic [CNT_W:0] tol;
        tol = nom >> TOL_SHIFT;
        return (val >= (nom - tol)) && (val <= (nom + tol));
    endfunction

    // ---------------------------------------------------------------- input sync
    logic r_piezo_m, r_piezo_s, r_piezo_d;
    logic w_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_piezo_m <= 1'b0;
            r_piezo_s <= 1'b0;
            r_piezo_d <= 1'b0;
        end else begin
            r_piezo_m <= piezo;
            r_piezo_s <= r_piezo_m;
            r_piezo_d <= r_piezo_s;
        end
    end

    assign w_rise = r_piezo_s & ~r_piezo_d;

    // ---------------------------------------------------------------- counters
    // Both counters restart at 0 on the rise cycle, so on the next rise they
    // hold one less than the measured interval; the +1 is added at capture.
    logic [CNT_W-1:0] r_period_cnt, r_high_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
        end else if (w_rise) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
        end else begin
            if (r_period_cnt != CNT_MAX)
                r_period_cnt <= r_period_cnt + CNT_ONE;
            if (r_piezo_s && (r_high_cnt != CNT_MAX))
                r_high_cnt <= r_high_cnt + CNT_ONE;
        end
    end

    logic [CNT_W:0] w_meas_p, w_meas_h;
    logic [2:0]     w_cls;

    assign w_meas_p = {1'b0, r_period_cnt} + M_ONE;
    assign w_meas_h = {1'b0, r_high_cnt} + M_ONE;

    always_comb begin
        w_cls = TONE_NONE;
        if (in_tol(w_meas_p, OVR_P) && in_tol(w_meas_h, OVR_H))
            w_cls = TONE_OVR;
        else if (in_tol(w_meas_p, BATT_P) && in_tol(w_meas_h, BATT_H))
            w_cls = TONE_BATT;
        else if (in_tol(w_meas_p, BATT_P) && in_tol(w_meas_h, BOTH_H))
            w_cls = TONE_BOTH;
        else if (in_tol(w_meas_p, NORM_P) && in_tol(w_meas_h, NORM_H))
            w_cls = TONE_NORM;
    end

    // ---------------------------------------------------------------- FSM
    state_t          r_state, w_state_next;
    logic [MC_W-1:0] r_match, w_match_next, w_match_acq;
    logic [2:0]      r_class, w_class_next;
    logic            w_cls_valid, w_same, w_timeout;

    // The timeout only matters while tracking; in IDLE a saturated counter
    // must not swallow the first rise.
    assign w_timeout   = (r_period_cnt == CNT_MAX) && (r_state != S_IDLE);
    assign w_cls_valid = (w_cls != TONE_NONE);
    assign w_same      = w_cls_valid && (w_cls == r_class);
    assign w_match_acq = w_same ? (r_match + MC_ONE) : (w_cls_valid ? MC_ONE : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_match <= '0;
            r_class <= TONE_NONE;
        end else begin
            r_state <= w_state_next;
            r_match <= w_match_next;
            r_class <= w_class_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_match_next = r_match;
        w_class_next = r_class;
        if (w_timeout) begin
            w_state_next = S_IDLE;
            w_match_next = '0;
            w_class_next = TONE_NONE;
        end else if (w_rise) begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_ACQ;
                    w_match_next = '0;
                    w_class_next = TONE_NONE;
                end
                S_ACQ: begin
                    w_match_next = w_match_acq;
                    w_class_next = w_cls;
                    if (w_match_acq == MC_LOCK)
                        w_state_next = S_LOCK;
                end
                S_LOCK: begin
                    if (!w_same) begin
                        w_state_next = S_ACQ;
                        w_match_next = w_cls_valid ? MC_ONE : '0;
                        w_class_next = w_cls;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Output decode: a tone is only reported on entering LOCK and withdrawn on
    // leaving it, so every tone_vld marks a real change of tone.
    logic [2:0] r_tone, w_tone_next;
    logic       r_tone_vld, w_vld_next;

    always_comb begin
        w_tone_next = r_tone;
        w_vld_next  = 1'b0;
        if ((r_state != S_LOCK) && (w_state_next == S_LOCK)) begin
            w_tone_next = w_class_next;
            w_vld_next  = 1'b1;
        end else if ((r_state == S_LOCK) && (w_state_next != S_LOCK)) begin
            w_tone_next = TONE_NONE;
            w_vld_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tone     <= TONE_NONE;
            r_tone_vld <= 1'b0;
        end else begin
            r_tone     <= w_tone_next;
            r_tone_vld <= w_vld_next;
        end
    end

    assign tone     = r_tone;
    assign tone_vld = r_tone_vld;

    // ---------------------------------------------------------------- diff check
`ifdef PIEZO_DIFF_CHK_EN
    logic       r_pn_m, r_pn_s;
    logic [1:0] r_eq_cnt;
    logic       r_diff_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pn_m     <= 1'b0;
            r_pn_s     <= 1'b0;
            r_eq_cnt   <= 2'd0;
            r_diff_err <= 1'b0;
        end else begin
            r_pn_m <= piezo_n;
            r_pn_s <= r_pn_m;
            if (r_piezo_s == r_pn_s) begin
                // Fourth consecutive equal cycle latches the error.
                if (r_eq_cnt == 2'd3)
                    r_diff_err <= 1'b1;
                else
                    r_eq_cnt <= r_eq_cnt + 2'd1;
            end else begin
                r_eq_cnt <= 2'd0;
            end
        end
    end

    assign diff_err = r_diff_err;
`else
    logic w_unused_piezo_n;
    assign w_unused_piezo_n = piezo_n;
    assign diff_err         = 1'b0;
`endif

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// -----------------------------------------------------------------------------
// tb_piezo_tone_decoder
//
// Drives piezo as a sequence of (period, high) intervals and checks, at the end
// of every interval, the tone output, the number of tone_vld pulses seen in the
// interval, and diff_err. Expected values come from an interval-level model of
// the tone rules. The DUT runs with CNT_W = 11, so every nominal timing is the
// full-size value divided by 64.
// -----------------------------------------------------------------------------
module tb_piezo_tone_decoder;

    localparam int CNT_W = 11;
    localparam int SC    = 17 - CNT_W;
    localparam int LOCKN = 4;
    localparam int TOLS  = 3;
    localparam int TO    = 1 << CNT_W;   // interval length that forces a timeout

    logic       clk = 1'b0;
    logic       rst_n;
    logic       piezo;
    logic       piezo_n;
    logic [2:0] tone;
    logic       tone_vld;
    logic       diff_err;

    piezo_tone_decoder #(
        .LOCK_CNT  (LOCKN),
        .TOL_SHIFT (TOLS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .piezo    (piezo),
        .piezo_n  (piezo_n),
        .tone     (tone),
        .tone_vld (tone_vld),
        .diff_err (diff_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int vld_cnt  = 0;

    always @(negedge clk) begin
        if (tone_vld === 1'b1)
            vld_cnt <= vld_cnt + 1;
    end

    // ------------------------------------------------ reference model
    int m_mode = 0;          // 0 idle, 1 acquiring, 2 locked
    int m_mc   = 0;
    int m_cls  = 0;
    int m_tone = 0;
    int m_prev_p = 0;
    int m_prev_h = 0;
    int m_vld  = 0;          // tone changes expected in the current interval

    function automatic bit near(input int v, input int nom);
        int t;
        t = nom >> TOLS;
        return (v >= nom - t) && (v <= nom + t);
    endfunction

    function automatic int classify(input int p, input int h);
        if (near(p, 16384 >> SC) && near(h, 8192  >> SC)) return 3;
        if (near(p, 32768 >> SC) && near(h, 16384 >> SC)) return 2;
        if (near(p, 32768 >> SC) && near(h, 24576 >> SC)) return 4;
        if (near(p, 65536 >> SC) && near(h, 32768 >> SC)) return 1;
        return 0;
    endfunction

    task automatic model_rise();
        int c;
        if (m_mode == 0) begin
            m_mode = 1;
            m_mc   = 0;
            m_cls  = 0;
        end else begin
            c = classify(m_prev_p, m_prev_h);
            if (m_mode == 1) begin
                m_mc  = (c != 0 && c == m_cls) ? m_mc + 1 : ((c != 0) ? 1 : 0);
                m_cls = c;
                if (m_mc == LOCKN) begin
                    m_mode = 2;
                    m_tone = c;
                    m_vld++;
                end
            end else if (c != m_cls) begin
                m_mode = 1;
                m_mc   = (c != 0) ? 1 : 0;
                m_cls  = c;
                m_tone = 0;
                m_vld++;
            end
        end
    endtask

    // ------------------------------------------------ helpers
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_interval(input string tag, input int p, input int h);
        int v0;
        m_vld = 0;
        model_rise();
        if (p >= TO && m_mode != 0) begin
            if (m_mode == 2) begin
                m_tone = 0;
                m_vld++;
            end
            m_mode = 0;
        end
        m_prev_p = p;
        m_prev_h = h;
        v0 = vld_cnt;
        piezo = 1'b1; piezo_n = 1'b0;
        cycles(h);
        piezo = 1'b0; piezo_n = 1'b1;
        cycles(p - h);
        $display("interval %s P=%0d H=%0d tone=%0d exp=%0d vld=%0d exp=%0d",
                 tag, p, h, tone, m_tone, vld_cnt - v0, m_vld);
        check({tag, "_tone"}, 32'(tone), 32'(m_tone));
        check({tag, "_vld"}, 32'(vld_cnt - v0), 32'(m_vld));
        check({tag, "_derr"}, 32'(diff_err), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        piezo = 1'b0; piezo_n = 1'b1;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check({tag, "_vld_in_rst"}, 32'(tone_vld), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset %s tone=%0d vld=%0d derr=%0d", tag, tone, tone_vld, diff_err);
        check({tag, "_tone"}, 32'(tone), 32'd0);
        check({tag, "_vld"}, 32'(tone_vld), 32'd0);
        check({tag, "_derr"}, 32'(diff_err), 32'd0);
        m_mode = 0; m_mc = 0; m_cls = 0; m_tone = 0;
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------ stimulus
    int nom_p [5] = '{65536 >> SC, 32768 >> SC, 16384 >> SC, 32768 >> SC, 0};
    int nom_h [5] = '{32768 >> SC, 16384 >> SC, 8192  >> SC, 24576 >> SC, 0};

    initial begin
        int n_int;
        int kind, run, p, h, tp, th;
        bit wide;

        rst_n = 1'b0; piezo = 1'b0; piezo_n = 1'b1;
        cycles(4);
        do_reset("por");

        // NORM square wave: locks after the 5th rise
        for (int i = 0; i < 5; i++) send_interval("norm", 1024, 512);
        send_interval("norm_to", TO + 250, 1);

        // BOTH wave locks, then stuck low times out to tone 0
        for (int i = 0; i < 5; i++) send_interval("both", 512, 384);
        send_interval("both_to", TO + 250, 1);

        // OVR lock, one bad period drops it, 4 more OVR periods relock
        for (int i = 0; i < 5; i++) send_interval("ovr", 256, 128);
        send_interval("ovr_bad", 468, 200);
        for (int i = 0; i < 5; i++) send_interval("ovr_re", 256, 128);
        send_interval("ovr_to", TO + 250, 1);

        // Tolerance boundaries: 224 and 288 lock, 223 never does
        for (int i = 0; i < 5; i++) send_interval("bnd_in", (i % 2 == 0) ? 224 : 288, 128);
        for (int i = 0; i < 6; i++) send_interval("bnd_out", 223, 128);
        send_interval("bnd_to", TO + 250, 1);

        // Reset while locked must not pulse tone_vld
        for (int i = 0; i < 5; i++) send_interval("pre_rst", 512, 256);
        do_reset("mid_lock");
        for (int i = 0; i < 5; i++) send_interval("post_rst", 256, 120);

        // Random runs of classes with jitter, sometimes just outside tolerance
        n_int = 0;
        while (n_int < 40) begin
            kind = $urandom_range(0, 4);
            run  = $urandom_range(1, 6);
            for (int r = 0; r < run; r++) begin
                if (kind == 4) begin
                    p = $urandom_range(150, 1200);
                    h = $urandom_range(1, p - 1);
                end else begin
                    wide = ($urandom_range(0, 7) == 0);
                    tp = (nom_p[kind] >> TOLS) + (wide ? 3 : 0);
                    th = (nom_h[kind] >> TOLS) + (wide ? 3 : 0);
                    p = nom_p[kind] - tp + $urandom_range(0, 2 * tp);
                    h = nom_h[kind] - th + $urandom_range(0, 2 * th);
                end
                send_interval("rnd", p, h);
                n_int++;
            end
        end

`ifdef PIEZO_DIFF_CHK_EN
        piezo = 1'b0; piezo_n = 1'b1;
        cycles(6);
        piezo = 1'b1; piezo_n = 1'b1;
        cycles(3);
        piezo = 1'b0; piezo_n = 1'b1;
        cycles(6);
        $display("diff 3 equal cycles derr=%0d", diff_err);
        check("diff_3cyc", 32'(diff_err), 32'd0);
        piezo = 1'b1; piezo_n = 1'b1;
        cycles(4);
        piezo = 1'b0; piezo_n = 1'b1;
        cycles(6);
        $display("diff 4 equal cycles derr=%0d", diff_err);
        check("diff_4cyc", 32'(diff_err), 32'd1);
        piezo = 1'b1; piezo_n = 1'b0;
        cycles(20);
        $display("diff held derr=%0d", diff_err);
        check("diff_held", 32'(diff_err), 32'd1);
        do_reset("diff_rst");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
